mult_div_unit: RTL



---
 rtl/mdu_pkg.sv | 29 ++
 rtl/mult_div_unit_if.sv | 27 ++
 rtl/mdu_datapath.sv | 87 ++++++++
 rtl/mult_div_unit.sv | 128 ++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// operation codes, FSM states and the default operand width.
package mdu_pkg;

  localparam int WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_SIGN = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  function automatic logic op_is_div(op_e op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic op_is_signed(op_e op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Start/busy/done handshake plus operand and result buses between the
// control unit (master) and the multiply/divide unit (slave).
interface mult_div_unit_if #(
  parameter int WIDTH = mdu_pkg::WIDTH_DEF
) ();

  logic             Start;
  logic [1:0]       Op;
  logic [WIDTH-1:0] OpA;
  logic [WIDTH-1:0] OpB;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] Hi;
  logic [WIDTH-1:0] Lo;
  logic             DivZero;

  modport master (
    output Start, Op, OpA, OpB,
    input  Busy, Done, Hi, Lo, DivZero
  );

  modport slave (
    input  Start, Op, OpA, OpB,
    output Busy, Done, Hi, Lo, DivZero
  );

endinterface

// File: rtl/mdu_datapath.sv
// Unsigned shift-add multiplier / restoring divider, one bit per step.
// Operands arrive as magnitudes; sign handling lives in the parent.
module mdu_datapath #(
  parameter int WIDTH = mdu_pkg::WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic               finish,
  input  logic               is_div,
  input  logic [WIDTH-1:0]   a_mag,
  input  logic [WIDTH-1:0]   b_mag,
  output logic [2*WIDTH-1:0] prod,
  output logic [WIDTH-1:0]   quot,
  output logic [WIDTH-1:0]   rem
);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  // Multiplier (shifts right) or dividend/quotient (shifts left)
  logic [WIDTH-1:0]   sr_q, sr_d;
  logic [WIDTH:0]     rem_q, rem_d;
  logic [WIDTH-1:0]   dvsr_q, dvsr_d;
  logic               is_div_q, is_div_d;

  logic [WIDTH+1:0]   shifted;
  logic [WIDTH:0]     diff;
  logic               ge;

  assign shifted = {rem_q, sr_q[WIDTH-1]};
  assign diff    = shifted[WIDTH:0] - {1'b0, dvsr_q};
  assign ge      = shifted >= {2'b00, dvsr_q};

  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    sr_d     = sr_q;
    rem_d    = rem_q;
    dvsr_d   = dvsr_q;
    is_div_d = is_div_q;
    if (load) begin
      acc_d    = '0;
      mcand_d  = {{WIDTH{1'b0}}, a_mag};
      sr_d     = is_div ? a_mag : b_mag;
      rem_d    = '0;
      dvsr_d   = b_mag;
      is_div_d = is_div;
    end else if (step) begin
      if (is_div_q) begin
        rem_d = ge ? diff : shifted[WIDTH:0];
        sr_d  = {sr_q[WIDTH-2:0], ge};
      end else begin
        acc_d   = sr_q[0] ? (acc_q + mcand_q) : acc_q;
        mcand_d = mcand_q << 1;
        sr_d    = sr_q >> 1;
      end
    end else if (finish) begin
      // Results are sampled by the parent on this same edge
      mcand_d = '0;
      dvsr_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      sr_q     <= '0;
      rem_q    <= '0;
      dvsr_q   <= '0;
      is_div_q <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      sr_q     <= sr_d;
      rem_q    <= rem_d;
      dvsr_q   <= dvsr_d;
      is_div_q <= is_div_d;
    end
  end

  assign prod = acc_q;
  assign quot = sr_q;
  assign rem  = rem_q[WIDTH-1:0];

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO result registers and a
// fixed 33-cycle start-to-result latency.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic            clk,
  input  logic            rst,
  mult_div_unit_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               div_q;
  logic               neg_res_q;
  logic               neg_rem_q;
  logic               bzero_q;
  logic [WIDTH-1:0]   opa_q;
  logic               busy_q;
  logic               done_q;
  logic               divzero_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;

  op_e                op_in;
  logic               accept;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] dp_prod, prod_fix;
  logic [WIDTH-1:0]   dp_quot, dp_rem, quot_fix, rem_fix;

  assign op_in  = op_e'(bus.Op);
  assign accept = bus.Start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign a_neg  = op_is_signed(op_in) && bus.OpA[WIDTH-1];
  assign b_neg  = op_is_signed(op_in) && bus.OpB[WIDTH-1];
  assign a_mag  = a_neg ? -bus.OpA : bus.OpA;
  assign b_mag  = b_neg ? -bus.OpB : bus.OpB;

  mdu_datapath #(
    .WIDTH (WIDTH)
  ) u_datapath (
    .clk    (clk),
    .rst    (rst),
    .load   (accept),
    .step   (state_q == ST_CALC),
    .finish (state_q == ST_SIGN),
    .is_div (op_is_div(op_in)),
    .a_mag  (a_mag),
    .b_mag  (b_mag),
    .prod   (dp_prod),
    .quot   (dp_quot),
    .rem    (dp_rem)
  );

  // Remainder follows the dividend's sign; quotient/product follow the XOR
  assign prod_fix = neg_res_q ? -dp_prod : dp_prod;
  assign quot_fix = neg_res_q ? -dp_quot : dp_quot;
  assign rem_fix  = neg_rem_q ? -dp_rem  : dp_rem;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      div_q     <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      bzero_q   <= 1'b0;
      opa_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      divzero_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            state_q   <= ST_CALC;
            busy_q    <= 1'b1;
            cnt_q     <= '0;
            divzero_q <= 1'b0;
            div_q     <= op_is_div(op_in);
            neg_res_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            bzero_q   <= (bus.OpB == '0);
            opa_q     <= bus.OpA;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_CALC: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_q <= ST_SIGN;
          end
        end
        ST_SIGN: begin
          if (div_q && bzero_q) begin
            lo_q      <= '1;
            hi_q      <= opa_q;
            divzero_q <= 1'b1;
          end else if (div_q) begin
            lo_q <= quot_fix;
            hi_q <= rem_fix;
          end else begin
            {hi_q, lo_q} <= prod_fix;
          end
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= ST_DONE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.Busy    = busy_q;
  assign bus.Done    = done_q;
  assign bus.Hi      = hi_q;
  assign bus.Lo      = lo_q;
  assign bus.DivZero = divzero_q;

endmodule
